// File: rtl/pwm_peripheral_if.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_peripheral_if
//  Purpose  : Bundles the SPI-register-file configuration bytes feeding the
//             PWM peripheral together with its pin-drive outputs.
//  Signals  : en_reg_out_7_0 / en_reg_out_15_8   output enables (SPI addr 0/1)
//             en_reg_pwm_7_0 / en_reg_pwm_15_8   PWM mode select (SPI addr 2/3)
//             pwm_duty_cycle                     duty in 1/256 steps (addr 4)
//             out                                registered pin drive
//             period_start                       pulse on first clk of period
//  Modports : master - register file side (drives config, observes pins)
//             slave  - PWM peripheral side
//  Revision : 1.0 - initial release
// ============================================================================
interface pwm_peripheral_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8,
    output en_reg_pwm_7_0, en_reg_pwm_15_8,
    output pwm_duty_cycle,
    input  out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8,
    input  en_reg_pwm_7_0, en_reg_pwm_15_8,
    input  pwm_duty_cycle,
    output out, period_start
  );
endinterface
`default_nettype wire

// File: rtl/pwm_peripheral.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_peripheral
//  Purpose  : Drives 16 output pins, each forced low, forced high, or driven
//             by one shared PWM waveform. The waveform comes from a prescaler
//             (PRESCALE clks per step) and an 8-bit period counter, giving a
//             period of 256*PRESCALE clks. The duty cycle is shadowed at each
//             period boundary so mid-period writes never produce runt pulses.
//  Ports    : clk    - system clock, rising edge
//             rst_n  - asynchronous active-low reset
//             bus    - pwm_peripheral_if.slave (config bytes in, pins out)
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_peripheral #(
  parameter int PRESCALE = 13
) (
  input wire              clk,
  input wire              rst_n,
  pwm_peripheral_if.slave bus
);

  localparam int             PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic [7:0]       pwm_cnt;
  logic [7:0]       duty_shadow;

  logic             tick;
  logic             boundary;
  logic [7:0]       cnt_next;
  logic [7:0]       duty_next;
  logic             lvl_next;
  logic [15:0]      en_out;
  logic [15:0]      en_pwm;
  logic [15:0]      out_next;

  always_comb begin
    tick     = (pre_cnt == PRE_MAX);
    boundary = tick && (pwm_cnt == 8'hFF);

    // Values the counter and shadow take on this edge. The pin register is
    // fed the level belonging to these, so the first clk of a new period
    // (period_start high) already shows pwm_cnt==0 with the new duty.
    cnt_next  = tick ? (pwm_cnt + 8'd1) : pwm_cnt;
    duty_next = boundary ? bus.pwm_duty_cycle : duty_shadow;

    // 0xFF is treated as full-on; otherwise the pin is high while the
    // counter is below the duty value.
    lvl_next  = (duty_next == 8'hFF) || (cnt_next < duty_next);

    en_out   = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    en_pwm   = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
    out_next = en_out & (~en_pwm | {16{lvl_next}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt          <= '0;
      pwm_cnt          <= 8'h00;
      duty_shadow      <= 8'h00;
      bus.out          <= 16'h0000;
      bus.period_start <= 1'b0;
    end else begin
      pre_cnt          <= tick ? '0 : (pre_cnt + PRE_W'(1));
      pwm_cnt          <= cnt_next;
      duty_shadow      <= duty_next;
      bus.out          <= out_next;
      bus.period_start <= boundary;
    end
  end

endmodule
`default_nettype wire
